// File: rtl/fmap_reader.sv
// fmap_reader: streams packed BRAM32k feature-map words one byte per cycle,
// byte 0 first, through a 2-word prefetch FIFO.
module fmap_reader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 64,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_cnt,
   output logic              busy,
   output logic              done,
   output logic              en_BRAM32k,
   output logic [ADDR_W-1:0] addr_BRAM32k_1,
   input  logic [DATA_W-1:0] dout_BRAM32k_1,
   output logic [7:0]        byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              byte_last
);
   localparam int NB = DATA_W / 8;
   localparam int IW = $clog2(NB);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [IW-1:0] IDX_END = IW'(NB-1);

   typedef enum logic [1:0] {IDLE, RUN, ZERO, FIN} state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   issue_rem;
   logic [ADDR_W:0]   pop_rem;
   logic [RD_LAT-1:0] rd_vld;
   logic [DATA_W-1:0] fifo [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        occ;
   logic [1:0]        inflight;
   logic [2:0]        pend;
   logic [IW-1:0]     idx;
   logic [DATA_W-1:0] head;
   logic              accept;
   logic              cnt_nz;
   logic              issue;
   logic              ret;
   logic              hs;
   logic              pop;

   always_comb begin
      inflight = 2'd0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + 2'(rd_vld[i]);
      end
   end

   assign pend   = {1'b0, occ} + {1'b0, inflight};
   assign cnt_nz = word_cnt != '0;
   assign accept = start & ~rst & (state == IDLE);
   // Reads in flight reserve their FIFO slot so a return never overflows.
   assign issue  = (accept & cnt_nz)
                 | ((state == RUN) & (issue_rem != '0) & (pend < 3'd2));
   assign ret    = rd_vld[RD_LAT-1];
   assign head   = fifo[rd_ptr];
   assign hs     = byte_valid & byte_ready;
   assign pop    = hs & (idx == IDX_END);

   assign byte_valid = occ != 2'd0;
   assign byte_out   = byte_valid ? head[{idx, 3'b000} +: 8] : 8'h00;
   assign byte_last  = byte_valid & (idx == IDX_END)
                     & (pop_rem == CNT_ONE);
   assign busy       = (state == RUN) | (state == ZERO);
   assign done       = state == FIN;
   assign en_BRAM32k = issue;
   assign addr_BRAM32k_1 = accept ? base_addr : addr_q;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (accept) state_nx = cnt_nz ? RUN : ZERO;
         end
         RUN: begin
            if (hs & byte_last) state_nx = FIN;
         end
         ZERO:    state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         issue_rem <= '0;
         pop_rem   <= '0;
         rd_vld    <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         occ       <= 2'd0;
         idx       <= '0;
      end else begin
         state     <= state_nx;
         rd_vld[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) begin
            rd_vld[i] <= rd_vld[i-1];
         end
         if (accept) begin
            addr_q    <= base_addr + ADDR_W'(cnt_nz);
            issue_rem <= word_cnt - (ADDR_W+1)'(cnt_nz);
            pop_rem   <= word_cnt;
            idx       <= '0;
         end else if (issue) begin
            addr_q    <= addr_q + 1'b1;
            issue_rem <= issue_rem - CNT_ONE;
         end
         if (pop) begin
            pop_rem <= pop_rem - CNT_ONE;
            rd_ptr  <= ~rd_ptr;
         end
         if (ret) wr_ptr <= ~wr_ptr;
         if (hs) idx <= idx + 1'b1;
         case ({ret, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (ret) fifo[wr_ptr] <= dout_BRAM32k_1;
   end

endmodule

// File: tb/tb_fmap_reader.sv
// Directed bench for fmap_reader: instance a uses RD_LAT=1, instance b
// RD_LAT=2; both read one behavioural BRAM image.
module tb_fmap_reader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_a, start_b;
   logic [11:0] base_a, base_b;
   logic [12:0] cnt_a, cnt_b;
   logic        busy_a, busy_b, done_a, done_b, en_a, en_b;
   logic [11:0] addr_a, addr_b;
   logic [63:0] dout_a, dout_b, stg_b;
   logic [7:0]  byte_a, byte_b;
   logic        valid_a, valid_b, ready_a, ready_b, last_a, last_b;

   logic [63:0] mem [4096];
   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   fmap_reader #(.ADDR_W(12), .DATA_W(64), .RD_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a),
      .base_addr(base_a), .word_cnt(cnt_a),
      .busy(busy_a), .done(done_a),
      .en_BRAM32k(en_a), .addr_BRAM32k_1(addr_a),
      .dout_BRAM32k_1(dout_a), .byte_out(byte_a),
      .byte_valid(valid_a), .byte_ready(ready_a),
      .byte_last(last_a)
   );

   fmap_reader #(.ADDR_W(12), .DATA_W(64), .RD_LAT(2)) dut_b (
      .clk(clk), .rst(rst), .start(start_b),
      .base_addr(base_b), .word_cnt(cnt_b),
      .busy(busy_b), .done(done_b),
      .en_BRAM32k(en_b), .addr_BRAM32k_1(addr_b),
      .dout_BRAM32k_1(dout_b), .byte_out(byte_b),
      .byte_valid(valid_b), .byte_ready(ready_b),
      .byte_last(last_b)
   );

   always @(posedge clk) begin
      if (en_a) dout_a <= mem[addr_a];
      if (en_b) stg_b <= mem[addr_b];
      dout_b <= stg_b;
   end

   logic [7:0]  hb_a[$], hb_b[$];
   bit          hl_a[$], hl_b[$];
   int          hc_a[$], hc_b[$];
   logic [11:0] ad_a[$], ad_b[$];
   int          dn_a, dn_b, dc_a, dc_b, stall_bad;
   bit          stalled;
   logic [7:0]  stall_byte;

   always @(negedge clk) begin
      if (valid_a && ready_a) begin
         hb_a.push_back(byte_a);
         hl_a.push_back(last_a);
         hc_a.push_back(cyc);
      end
      if (stalled && byte_a !== stall_byte) stall_bad++;
      stalled = valid_a && !ready_a;
      stall_byte = byte_a;
      if (done_a) begin dn_a++; dc_a = cyc; end
      if (en_a) ad_a.push_back(addr_a);
      if (valid_b && ready_b) begin
         hb_b.push_back(byte_b);
         hl_b.push_back(last_b);
         hc_b.push_back(cyc);
      end
      if (done_b) begin dn_b++; dc_b = cyc; end
      if (en_b) ad_b.push_back(addr_b);
   end

   function automatic logic [7:0] exp_byte(int a, int k);
      logic [63:0] w;
      w = mem[a % 4096];
      return w[8*k +: 8];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      hb_a.delete(); hl_a.delete(); hc_a.delete(); ad_a.delete();
      hb_b.delete(); hl_b.delete(); hc_b.delete(); ad_b.delete();
      dn_a = 0; dn_b = 0; dc_a = 0; dc_b = 0;
      stall_bad = 0; stalled = 0;
   endtask

   task automatic go_a(input logic [11:0] b, input logic [12:0] n,
                       output int sc);
      base_a = b; cnt_a = n; start_a = 1'b1;
      sc = cyc;
      tick();
      start_a = 1'b0;
   endtask

   task automatic go_b(input logic [11:0] b, input logic [12:0] n,
                       output int sc);
      base_b = b; cnt_b = n; start_b = 1'b1;
      sc = cyc;
      tick();
      start_b = 1'b0;
   endtask

   task automatic wait_a(input int target, input int bound,
                         output bit ok);
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (dn_a >= target) begin ok = 1; break; end
      end
   endtask

   task automatic timeout_chk(input bit ok, input string nm);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s timeout waiting for done", nm);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_a = 0; start_b = 0; ready_a = 1; ready_b = 1;
      base_a = 0; base_b = 0; cnt_a = 0; cnt_b = 0;
      repeat (3) tick();
      checks++;
      if ({busy_a, done_a, en_a, valid_a, last_a} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctl_a got %b exp 00000",
                  {busy_a, done_a, en_a, valid_a, last_a});
      end
      checks++;
      if ({addr_a, byte_a} !== 20'h0) begin
         failures++;
         $display("FAIL reset_data_a got %h exp 00000",
                  {addr_a, byte_a});
      end
      checks++;
      if ({busy_b, done_b, en_b, valid_b, last_b, byte_b} !== 13'h0) begin
         failures++;
         $display("FAIL reset_b got %h exp 0",
                  {busy_b, done_b, en_b, valid_b, last_b, byte_b});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int sc; bit ok;
      clear_log();
      ready_a = 1'b1;
      go_a(12'h010, 13'd2, sc);
      checks++;
      if (busy_a !== 1'b1) begin
         failures++;
         $display("FAIL basic_busy got %b exp 1", busy_a);
      end
      wait_a(1, 60, ok);
      repeat (4) tick();
      timeout_chk(ok, "basic");
      checks++;
      if (hb_a.size() != 16) begin
         failures++;
         $display("FAIL basic_count got %0d exp 16", hb_a.size());
      end
      for (int i = 0; i < 16 && i < hb_a.size(); i++) begin
         checks++;
         if (hb_a[i] !== 8'(i + 1) || hl_a[i] !== (i == 15)) begin
            failures++;
            $display("FAIL basic_byte%0d got %h/%b exp %h/%b", i,
                     hb_a[i], hl_a[i], 8'(i + 1), i == 15);
         end
      end
      if (hc_a.size() == 16) begin
         checks++;
         if (hc_a[0] - sc != 2 || hc_a[15] - hc_a[0] != 15) begin
            failures++;
            $display("FAIL basic_timing got first=%0d span=%0d exp 2/15",
                     hc_a[0] - sc, hc_a[15] - hc_a[0]);
         end
         checks++;
         if (dn_a != 1 || dc_a != hc_a[15] + 1) begin
            failures++;
            $display("FAIL basic_done got n=%0d at=%0d exp 1 at %0d",
                     dn_a, dc_a, hc_a[15] + 1);
         end
      end
      checks++;
      if (ad_a.size() != 2 || ad_a[0] !== 12'h010
          || ad_a[1] !== 12'h011) begin
         failures++;
         $display("FAIL basic_addr got n=%0d exp 010,011", ad_a.size());
      end
   endtask

   task automatic test_backpressure();
      int sc; bit ok;
      clear_log();
      ready_a = 1'b1;
      go_a(12'h020, 13'd1, sc);
      ok = 0;
      for (int n = 0; n < 200; n++) begin
         ready_a = (n % 4 == 0) || (n % 4 == 3);
         tick();
         if (dn_a > 0) begin ok = 1; break; end
      end
      ready_a = 1'b1;
      repeat (4) tick();
      timeout_chk(ok, "bp");
      checks++;
      if (hb_a.size() != 8 || dn_a != 1) begin
         failures++;
         $display("FAIL bp_count got hs=%0d done=%0d exp 8/1",
                  hb_a.size(), dn_a);
      end
      for (int i = 0; i < 8 && i < hb_a.size(); i++) begin
         checks++;
         if (hb_a[i] !== exp_byte(12'h020, i)) begin
            failures++;
            $display("FAIL bp_byte%0d got %h exp %h", i, hb_a[i],
                     exp_byte(12'h020, i));
         end
      end
      checks++;
      if (stall_bad != 0) begin
         failures++;
         $display("FAIL bp_hold got %0d changes exp 0", stall_bad);
      end
   endtask

   task automatic test_wrap();
      int sc; bit ok;
      clear_log();
      go_a(12'hFFF, 13'd3, sc);
      wait_a(1, 80, ok);
      timeout_chk(ok, "wrap");
      checks++;
      if (ad_a.size() != 3 || ad_a[0] !== 12'hFFF
          || ad_a[1] !== 12'h000 || ad_a[2] !== 12'h001) begin
         failures++;
         $display("FAIL wrap_addr got n=%0d exp FFF,000,001", ad_a.size());
      end
      checks++;
      if (hb_a.size() != 24) begin
         failures++;
         $display("FAIL wrap_count got %0d exp 24", hb_a.size());
      end
      for (int i = 0; i < 24 && i < hb_a.size(); i++) begin
         checks++;
         if (hb_a[i] !== exp_byte(4095 + i / 8, i % 8)) begin
            failures++;
            $display("FAIL wrap_byte%0d got %h exp %h", i, hb_a[i],
                     exp_byte(4095 + i / 8, i % 8));
         end
      end
   endtask

   task automatic test_zero_busy_start();
      int sc, dummy; bit ok;
      clear_log();
      go_a(12'h050, 13'd0, sc);
      checks++;
      if (busy_a !== 1'b1) begin
         failures++;
         $display("FAIL zero_busy got %b exp 1", busy_a);
      end
      wait_a(1, 10, ok);
      tick();
      timeout_chk(ok, "zero");
      checks++;
      if (dc_a - sc != 2 || ad_a.size() != 0 || hb_a.size() != 0) begin
         failures++;
         $display("FAIL zero_done got lat=%0d rd=%0d exp 2/0",
                  dc_a - sc, ad_a.size());
      end
      clear_log();
      go_a(12'h040, 13'd4, sc);
      repeat (10) tick();
      go_a(12'h200, 13'd1, dummy);
      wait_a(1, 100, ok);
      repeat (20) tick();
      timeout_chk(ok, "busy_start");
      checks++;
      if (hb_a.size() != 32 || dn_a != 1 || ad_a.size() != 4) begin
         failures++;
         $display("FAIL busy_start got hs=%0d done=%0d rd=%0d exp 32/1/4",
                  hb_a.size(), dn_a, ad_a.size());
      end
      for (int i = 0; i < 32 && i < hb_a.size(); i++) begin
         checks++;
         if (hb_a[i] !== exp_byte(12'h040 + i / 8, i % 8)) begin
            failures++;
            $display("FAIL busy_start_byte%0d got %h exp %h", i, hb_a[i],
                     exp_byte(12'h040 + i / 8, i % 8));
         end
      end
   endtask

   task automatic test_back_to_back();
      int sc1, sc2; bit ok;
      clear_log();
      go_a(12'h060, 13'd1, sc1);
      wait_a(1, 40, ok);
      go_a(12'h061, 13'd1, sc2);
      wait_a(2, 40, ok);
      tick();
      timeout_chk(ok, "b2b");
      checks++;
      if (hb_a.size() != 16 || dn_a != 2) begin
         failures++;
         $display("FAIL b2b_count got hs=%0d done=%0d exp 16/2",
                  hb_a.size(), dn_a);
      end
      if (hc_a.size() == 16) begin
         checks++;
         if (hc_a[8] - sc2 != 2) begin
            failures++;
            $display("FAIL b2b_lat got %0d exp 2", hc_a[8] - sc2);
         end
      end
      for (int i = 0; i < 16 && i < hb_a.size(); i++) begin
         checks++;
         if (hb_a[i] !== exp_byte(12'h060 + i / 8, i % 8)) begin
            failures++;
            $display("FAIL b2b_byte%0d got %h exp %h", i, hb_a[i],
                     exp_byte(12'h060 + i / 8, i % 8));
         end
      end
   endtask

   task automatic test_reset_mid();
      int sc; bit ok;
      clear_log();
      go_a(12'h080, 13'd8, sc);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (hb_a.size() >= 13) begin ok = 1; break; end
      end
      timeout_chk(ok, "rst_mid_reach");
      rst = 1'b1;
      tick();
      checks++;
      if ({busy_a, done_a, en_a, valid_a, last_a} !== 5'b0
          || {addr_a, byte_a} !== 20'h0) begin
         failures++;
         $display("FAIL rst_mid_out got %b %h exp 0",
                  {busy_a, done_a, en_a, valid_a, last_a},
                  {addr_a, byte_a});
      end
      rst = 1'b0;
      clear_log();
      repeat (10) tick();
      checks++;
      if (dn_a != 0 || hb_a.size() != 0 || ad_a.size() != 0) begin
         failures++;
         $display("FAIL rst_mid_quiet got done=%0d hs=%0d rd=%0d exp 0",
                  dn_a, hb_a.size(), ad_a.size());
      end
      go_a(12'h100, 13'd1, sc);
      wait_a(1, 40, ok);
      tick();
      timeout_chk(ok, "restart");
      checks++;
      if (hb_a.size() != 8 || dn_a != 1) begin
         failures++;
         $display("FAIL restart_count got hs=%0d done=%0d exp 8/1",
                  hb_a.size(), dn_a);
      end
      for (int i = 0; i < 8 && i < hb_a.size(); i++) begin
         checks++;
         if (hb_a[i] !== exp_byte(12'h100, i)) begin
            failures++;
            $display("FAIL restart_byte%0d got %h exp %h", i, hb_a[i],
                     exp_byte(12'h100, i));
         end
      end
   endtask

   task automatic test_lat2();
      int sc; bit ok;
      clear_log();
      ready_b = 1'b1;
      go_b(12'h300, 13'd4, sc);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (dn_b > 0) begin ok = 1; break; end
      end
      tick();
      timeout_chk(ok, "lat2");
      checks++;
      if (hb_b.size() != 32 || dn_b != 1) begin
         failures++;
         $display("FAIL lat2_count got hs=%0d done=%0d exp 32/1",
                  hb_b.size(), dn_b);
      end
      if (hc_b.size() == 32) begin
         checks++;
         if (hc_b[0] - sc != 3 || hc_b[31] - hc_b[0] != 31) begin
            failures++;
            $display("FAIL lat2_timing got first=%0d span=%0d exp 3/31",
                     hc_b[0] - sc, hc_b[31] - hc_b[0]);
         end
         checks++;
         if (hl_b[31] !== 1'b1 || hl_b[23] !== 1'b0
             || dc_b != hc_b[31] + 1) begin
            failures++;
            $display("FAIL lat2_last got %b%b done_at=%0d exp 10 at %0d",
                     hl_b[31], hl_b[23], dc_b, hc_b[31] + 1);
         end
      end
      for (int i = 0; i < 32 && i < hb_b.size(); i++) begin
         checks++;
         if (hb_b[i] !== exp_byte(12'h300 + i / 8, i % 8)) begin
            failures++;
            $display("FAIL lat2_byte%0d got %h exp %h", i, hb_b[i],
                     exp_byte(12'h300 + i / 8, i % 8));
         end
      end
      checks++;
      if (ad_b.size() != 4 || ad_b[3] !== 12'h303) begin
         failures++;
         $display("FAIL lat2_addr got n=%0d exp 4 ending 303", ad_b.size());
      end
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) begin
         for (int k = 0; k < 8; k++) begin
            mem[a][8*k +: 8] = 8'(a * 13 + k * 37 + 5);
         end
      end
      mem[12'h010] = 64'h0807060504030201;
      mem[12'h011] = 64'h100F0E0D0C0B0A09;
      clear_log();
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_busy_start();
      test_back_to_back();
      test_reset_mid();
      test_lat2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fmap_reader.md
Name: fmap_reader

Overview:
- Read-side counterpart of the PE-group writeback path.
- Fetches packed 64-bit feature-map words from BRAM32k, unpacks each word into 8 bytes, and streams them one byte per cycle to the PE-group input over a valid/ready handshake.
- Sits between BRAM32k port 1 (read) and the PE-group operand feed. Started by the layer controller with a base address and a word count.

Parameters:
- ADDR_W, 12, BRAM32k word-address width.
- DATA_W, 64, BRAM32k word width (8 bytes).
- RD_LAT, 1, BRAM read latency in cycles (address to dout); legal values 1 or 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- base_addr  in  12  first word address, latched on accepted start.
- word_cnt  in  13  number of words to read, 0..4096, latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last byte is accepted.
- en_BRAM32k  out  1  read enable to BRAM32k port 1.
- addr_BRAM32k_1  out  12  read address.
- dout_BRAM32k_1  in  64  read data, valid RD_LAT cycles after en_BRAM32k.
- byte_out  out  8  current unpacked byte.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  consumer accepts byte_out this cycle.
- byte_last  out  1  qualifies the final byte of the transfer.

Behaviour:
- Reset, synchronous and applied on the clock edge: all outputs 0, FSM to IDLE, buffers emptied.
  - Reset mid-transfer aborts the transfer; BRAM data still in flight is discarded; no done pulse.
- Byte order: byte k of a word is dout[8k+7:8k]. Byte 0 (bits 7:0) goes out first, byte 7 (bits 63:56) last. This is the inverse of the writeback packing order.
- Accepted start latches base_addr and word_cnt. A start while busy=1 is ignored.
- word_cnt=0: no BRAM read; busy=1 for one cycle, then done=1 for one cycle.
- Word buffer: 2-entry FIFO of 64-bit words.
  - A read issues (en_BRAM32k=1 for one cycle) when words remaining to issue > 0 and (occupied entries + reads in flight) < 2.
  - The read address increments by 1 per issued read and wraps 4095 -> 0.
  - Returning data is written to the FIFO exactly RD_LAT cycles after issue, tracked by an RD_LAT-deep valid shift register.
- Unpacker:
  - A 3-bit byte index selects a byte from the FIFO head.
  - byte_valid=1 whenever the FIFO is non-empty.
  - A handshake occurs when byte_valid & byte_ready. It advances the index; index 7 -> 0 pops the head.
  - byte_out and byte_valid hold stable while byte_ready=0.
- Throughput: with byte_ready held high, sustained 1 byte/cycle.
  - First byte_valid occurs RD_LAT+1 cycles after the cycle start is accepted.
  - There are no bubbles between words, because the second FIFO entry prefetches.
- Pop and BRAM return in the same cycle: both take effect; occupancy unchanged.
- byte_last=1 with byte_valid on byte index 7 of the final word.
- done pulses the cycle after the last handshake. busy falls in that same cycle.
- FSM states and transitions:
  - IDLE -> RUN on accepted start with word_cnt>0.
  - IDLE -> ZERO on accepted start with word_cnt=0.
  - RUN -> FIN on the handshake with byte_last.
  - ZERO -> FIN.
  - FIN -> IDLE; done=1 in FIN.
- A new start is accepted in the cycle after FIN, giving back-to-back transfers.

Test Plan:
- Basic: base=0x010, cnt=2, mem[0x010]=0x0807060504030201, mem[0x011]=0x100F0E0D0C0B0A09, ready=1 -> bytes 0x01..0x10 on 16 consecutive cycles; byte_last on 0x10; done one cycle later; addresses 0x010, 0x011 only.
- Backpressure: cnt=1, byte_ready toggled 1,0,0,1,... -> byte_out held while ready=0; no byte lost or duplicated; exactly 8 handshakes before done.
- Wrap: base=0xFFF, cnt=3 -> read addresses 0xFFF, 0x000, 0x001; 24 bytes in order.
- Zero count plus busy start: start with cnt=0 -> no en_BRAM32k, done 2 cycles after start. A start pulsed during a cnt=4 transfer is ignored: 32 bytes only, one done.
- Reset mid-op: cnt=8, assert rst at byte 13 -> next cycle all outputs 0, no done. A restart with base=0x100, cnt=1 then streams mem[0x100] correctly.
- RD_LAT=2 build: cnt=4, ready=1 -> first valid 3 cycles after start, then 32 gap-free bytes.
